// File: rtl/autoidx_seq_if.sv
// Memory bus between the auto-index sequencer (master) and the bus arbiter
// (slave). Single request/acknowledge access with a write-enable qualifier.
interface autoidx_seq_if;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/autoidx_seq.sv
// Auto-index sequencer. On an accepted start it reads the pointer word at
// {6'b0, ir}, writes back the incremented/decremented pointer and reports the
// effective address with a one-cycle done pulse. Mode 00 bypasses the bus.
// Each bus access is abandoned after TIMEOUT unacknowledged wait cycles
// (TIMEOUT = 0 waits forever); the abandoned sequence ends with done + err.
// Optional feature macro: AUTOIDX_WRAP_EN -- when defined, wrap pulses in the
// done cycle if the pointer update crossed 16'hFFFF <-> 16'h0000.
module autoidx_seq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  ir,
   input  logic [1:0]  idx,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] ea,
   output logic        wrap,
   autoidx_seq_if.master bus
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t        state;
   logic [1:0]    idx_reg;
   logic [CW-1:0] cnt;
   logic [15:0]   ea_pend;
   logic [15:0]   upd_val;
   logic [15:0]   ea_val;
   logic          tmo;

   // Wait budget exhausted for the current access (never when TIMEOUT = 0).
   assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

   // Updated pointer and effective address derived from the word being read.
   always_comb begin
      upd_val = bus.mem_rdata + 16'd1;
      ea_val  = bus.mem_rdata;
      case (idx_reg)
         2'b10: begin
            upd_val = bus.mem_rdata - 16'd1;
            ea_val  = bus.mem_rdata - 16'd1;
         end
         2'b11: begin
            upd_val = bus.mem_rdata + 16'd1;
            ea_val  = bus.mem_rdata + 16'd1;
         end
         default: begin
            upd_val = bus.mem_rdata + 16'd1;
            ea_val  = bus.mem_rdata;
         end
      endcase
   end

`ifdef AUTOIDX_WRAP_EN
   logic wrap_val;
   logic wrap_pend;
   logic wrap_q;

   assign wrap = wrap_q;

   // Boundary crossing: decrement from 0, or increment from all-ones.
   always_comb begin
      wrap_val = (idx_reg == 2'b10) ? (bus.mem_rdata == 16'h0000)
                                    : (bus.mem_rdata == 16'hFFFF);
   end
`else
   assign wrap = 1'b0;
`endif

   // Sequencer FSM; every output is registered and set on state entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         idx_reg       <= 2'b00;
         cnt           <= '0;
         ea_pend       <= 16'h0000;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         ea            <= 16'h0000;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 16'h0000;
         bus.mem_wdata <= 16'h0000;
`ifdef AUTOIDX_WRAP_EN
         wrap_pend     <= 1'b0;
         wrap_q        <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef AUTOIDX_WRAP_EN
         wrap_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  idx_reg      <= idx;
                  bus.mem_addr <= {6'b0, ir};
                  busy         <= 1'b1;
                  if (idx == 2'b00) begin
                     // No pointer update: the operand field is the address.
                     ea    <= {6'b0, ir};
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     bus.mem_req <= 1'b1;
                     bus.mem_we  <= 1'b0;
                     cnt         <= '0;
                     state       <= READ;
                  end
               end
            end
            READ: begin
               if (bus.mem_ack) begin
                  // Keep mem_req high; only the direction flips for the write.
                  bus.mem_wdata <= upd_val;
                  ea_pend       <= ea_val;
`ifdef AUTOIDX_WRAP_EN
                  wrap_pend     <= wrap_val;
`endif
                  bus.mem_we    <= 1'b1;
                  cnt           <= '0;
                  state         <= WRITE;
               end else if (tmo) begin
                  bus.mem_req <= 1'b0;
                  done        <= 1'b1;
                  err         <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  ea          <= ea_pend;
                  done        <= 1'b1;
`ifdef AUTOIDX_WRAP_EN
                  wrap_q      <= wrap_pend;
`endif
                  state       <= DONE;
               end else if (tmo) begin
                  // Unconfirmed write: leave ea at its previous value.
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  done        <= 1'b1;
                  err         <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               bus.mem_req <= 1'b0;
               bus.mem_we  <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_autoidx_seq.sv
// Bench for autoidx_seq: vector table, randomized transactions against a
// spec-level model, timeout and mid-access reset on a TIMEOUT=4 instance.
// Honours AUTOIDX_WRAP_EN for the expected wrap value.
module tb_autoidx_seq;

`ifdef AUTOIDX_WRAP_EN
   localparam bit WRAP_ON = 1'b1;
`else
   localparam bit WRAP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset0, reset1;
   logic        start0, start1;
   logic [9:0]  ir0, ir1;
   logic [1:0]  idx0, idx1;
   logic        busy0, done0, err0, wrap0;
   logic        busy1, done1, err1, wrap1;
   logic [15:0] ea0, ea1;

   autoidx_seq_if bus0();
   autoidx_seq_if bus1();

   autoidx_seq #(.TIMEOUT(255)) dut0 (
      .clk(clk), .reset(reset0), .start(start0), .ir(ir0), .idx(idx0),
      .busy(busy0), .done(done0), .err(err0), .ea(ea0), .wrap(wrap0),
      .bus(bus0)
   );

   autoidx_seq #(.TIMEOUT(4)) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .ir(ir1), .idx(idx1),
      .busy(busy1), .done(done1), .err(err1), .ea(ea1), .wrap(wrap1),
      .bus(bus1)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---- memory responder for dut0: ack after a programmed number of waits
   int          rd_wait = 0, wr_wait = 0;
   logic [15:0] p_val = 16'h0000;
   int          rd_count = 0, wr_count = 0, req_cycles = 0, stab_err = 0;
   logic [15:0] rd_addr = 16'h0, wr_addr = 16'h0, wr_data = 16'h0;

   initial begin
      bit          in_acc;
      logic        cur_we;
      int          cyc;
      logic [15:0] acc_addr;
      in_acc = 1'b0; cur_we = 1'b0; cyc = 0; acc_addr = 16'h0;
      bus0.mem_ack   = 1'b0;
      bus0.mem_rdata = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (bus0.mem_req === 1'b1) begin
            req_cycles++;
            if (!in_acc || bus0.mem_we !== cur_we) begin
               in_acc = 1'b1; cur_we = bus0.mem_we; cyc = 0; acc_addr = bus0.mem_addr;
            end else begin
               cyc++;
               if (bus0.mem_addr !== acc_addr) stab_err++;
            end
            if (cyc >= (cur_we ? wr_wait : rd_wait)) begin
               bus0.mem_ack = 1'b1;
               if (cur_we) begin
                  wr_count++; wr_addr = bus0.mem_addr; wr_data = bus0.mem_wdata;
               end else begin
                  rd_count++; rd_addr = bus0.mem_addr;
               end
            end else begin
               bus0.mem_ack = 1'b0;
            end
         end else begin
            in_acc = 1'b0;
            bus0.mem_ack = 1'b0;
         end
         bus0.mem_rdata = p_val;
      end
   end

   // dut1 never gets an acknowledge; count any write cycles it issues
   int wr1 = 0;
   initial begin
      bus1.mem_ack   = 1'b0;
      bus1.mem_rdata = 16'h5A5A;
   end
   always @(posedge clk)
      if (bus1.mem_req === 1'b1 && bus1.mem_we === 1'b1) wr1 <= wr1 + 1;

   typedef struct {
      logic [1:0]  i;
      logic [9:0]  r;
      logic [15:0] p;
      int          rw;
      int          ww;
      bit          poke;
      logic [15:0] e_ea;
      logic [15:0] e_wd;
      int          e_lat;
      bit          e_wrap;
   } vec_t;

   // Reference: pointer semantics of the three auto-index modes.
   function automatic vec_t model(input logic [1:0] i, input logic [9:0] r, input logic [15:0] p,
                                  input int rw, input int ww, input bit poke);
      vec_t v;
      v.i = i; v.r = r; v.p = p; v.rw = rw; v.ww = ww; v.poke = poke;
      if (i == 2'b00) begin
         v.e_ea = {6'b0, r}; v.e_wd = 16'h0; v.e_lat = 1; v.e_wrap = 1'b0;
      end else begin
         v.e_wd   = (i == 2'b10) ? 16'(p - 16'd1) : 16'(p + 16'd1);
         v.e_ea   = (i == 2'b01) ? p : v.e_wd;
         v.e_lat  = 3 + rw + ww;
         v.e_wrap = (i == 2'b10) ? (p == 16'h0000) : (p == 16'hFFFF);
      end
      return v;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int lat, b_rd, b_wr, b_req, b_stab;
      @(negedge clk);
      rd_wait = v.rw; wr_wait = v.ww; p_val = v.p;
      b_rd = rd_count; b_wr = wr_count; b_req = req_cycles; b_stab = stab_err;
      start0 = 1'b1; idx0 = v.i; ir0 = v.r;
      @(negedge clk);
      start0 = 1'b0; lat = 1;
      while (done0 !== 1'b1 && lat < 100) begin
         if (v.poke) begin start0 = 1'b1; idx0 = ~v.i; ir0 = ~v.r; end
         @(negedge clk);
         start0 = 1'b0; lat++;
      end
      if (v.poke) begin start0 = 1'b1; idx0 = ~v.i; ir0 = ~v.r; end
      check({tag, " latency"}, lat, v.e_lat);
      check({tag, " ea"}, ea0, v.e_ea);
      check({tag, " err"}, err0, 1'b0);
      check({tag, " wrap"}, wrap0, v.e_wrap & WRAP_ON);
      check({tag, " busy_in_done"}, busy0, 1'b1);
      if (v.i != 2'b00) begin
         check({tag, " reads"}, rd_count - b_rd, 1);
         check({tag, " writes"}, wr_count - b_wr, 1);
         check({tag, " rd_addr"}, rd_addr, {6'b0, v.r});
         check({tag, " wr_addr"}, wr_addr, {6'b0, v.r});
         check({tag, " wdata"}, wr_data, v.e_wd);
         check({tag, " addr_stable"}, stab_err - b_stab, 0);
      end else begin
         check({tag, " no_bus"}, req_cycles - b_req, 0);
      end
      @(negedge clk);
      start0 = 1'b0;
      check({tag, " done_1cyc"}, done0, 1'b0);
      check({tag, " idle_after"}, busy0, 1'b0);
      check({tag, " ea_held"}, ea0, v.e_ea);
      $display("txn %s idx=%0d ir=%03h p=%04h waits=%0d/%0d ea=%04h lat=%0d", tag, v.i, v.r, v.p,
               v.rw, v.ww, ea0, lat);
   endtask

   vec_t vecs[9];

   initial begin
      int lat, wbase;
      vecs[0] = '{2'b00, 10'h155, 16'h0000, 0, 0, 1'b0, 16'h0155, 16'h0000, 1,  1'b0};
      vecs[1] = '{2'b01, 10'h340, 16'h1234, 0, 0, 1'b0, 16'h1234, 16'h1235, 3,  1'b0};
      vecs[2] = '{2'b10, 10'h010, 16'h0000, 0, 0, 1'b0, 16'hFFFF, 16'hFFFF, 3,  1'b1};
      vecs[3] = '{2'b11, 10'h3FF, 16'hFFFF, 5, 5, 1'b0, 16'h0000, 16'h0000, 13, 1'b1};
      vecs[4] = '{2'b10, 10'h001, 16'h8000, 2, 0, 1'b0, 16'h7FFF, 16'h7FFF, 5,  1'b0};
      vecs[5] = '{2'b11, 10'h222, 16'h00FF, 0, 3, 1'b0, 16'h0100, 16'h0100, 6,  1'b0};
      vecs[6] = '{2'b01, 10'h0AA, 16'hFFFF, 1, 1, 1'b0, 16'hFFFF, 16'h0000, 5,  1'b1};
      vecs[7] = '{2'b01, 10'h123, 16'h4000, 3, 3, 1'b1, 16'h4000, 16'h4001, 9,  1'b0};
      vecs[8] = '{2'b00, 10'h2C3, 16'h0000, 0, 0, 1'b1, 16'h02C3, 16'h0000, 1,  1'b0};

      reset0 = 1'b1; reset1 = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      ir0 = 10'h0; ir1 = 10'h0; idx0 = 2'b00; idx1 = 2'b00;
      repeat (2) @(negedge clk);
      reset0 = 1'b0; reset1 = 1'b0;
      @(negedge clk);
      check("rst busy", busy0, 1'b0);
      check("rst done", done0, 1'b0);
      check("rst err", err0, 1'b0);
      check("rst wrap", wrap0, 1'b0);
      check("rst ea", ea0, 16'h0000);
      check("rst req", bus0.mem_req, 1'b0);
      check("rst we", bus0.mem_we, 1'b0);
      check("rst addr", bus0.mem_addr, 16'h0000);
      check("rst wdata", bus0.mem_wdata, 16'h0000);

      foreach (vecs[k]) run_txn(vecs[k], $sformatf("vec%0d", k));

      for (int n = 0; n < 40; n++) begin
         logic [15:0] p;
         case ($urandom_range(0, 3))
            0:       p = 16'hFFFF;
            1:       p = 16'h0000;
            default: p = 16'($urandom);
         endcase
         run_txn(model(2'($urandom_range(0, 3)), 10'($urandom), p,
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1))), $sformatf("rnd%0d", n));
      end

      // Timeout instance: establish a known ea, then a read that never acks.
      @(negedge clk);
      start1 = 1'b1; idx1 = 2'b00; ir1 = 10'h0AB;
      @(negedge clk);
      start1 = 1'b0;
      check("to m0 done", done1, 1'b1);
      check("to m0 ea", ea1, 16'h00AB);
      @(negedge clk);
      wbase = wr1;
      start1 = 1'b1; idx1 = 2'b01; ir1 = 10'h1C0;
      @(negedge clk);
      start1 = 1'b0; lat = 1;
      while (done1 !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("to latency", lat, 6);
      check("to err", err1, 1'b1);
      check("to ea_kept", ea1, 16'h00AB);
      check("to wrap", wrap1, 1'b0);
      check("to no_write", wr1 - wbase, 0);
      check("to req_low", bus1.mem_req, 1'b0);
      $display("txn timeout lat=%0d err=%0d ea=%04h", lat, err1, ea1);
      @(negedge clk);
      check("to idle busy", busy1, 1'b0);
      check("to err_1cyc", err1, 1'b0);

      // Reset while the read is outstanding must drop the request at once.
      start1 = 1'b1; idx1 = 2'b11; ir1 = 10'h2F0;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      check("mid req_high", bus1.mem_req, 1'b1);
      check("mid busy_high", busy1, 1'b1);
      reset1 = 1'b1;
      #1;
      check("mid rst req", bus1.mem_req, 1'b0);
      check("mid rst busy", busy1, 1'b0);
      check("mid rst addr", bus1.mem_addr, 16'h0000);
      $display("txn mid_read_reset req=%0d busy=%0d", bus1.mem_req, busy1);
      @(negedge clk);
      reset1 = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
